// File: rtl/vexriscv_axi_pkg.sv
// Shared widths, payload field offsets and FSM states for the VexRiscv AXI read arbiter.
// AR payload is {addr, id, len, size, burst, lock, cache, prot, qos}; R payload is {data, id, resp, last}.
package vexriscv_axi_pkg;

    localparam int AR_LEN_LSB = 17;
    localparam int AR_LEN_W   = 8;
    localparam int AR_ID_LSB  = 25;
    localparam int R_LAST_BIT = 0;
    localparam int R_ID_LSB   = 3;

    function automatic int ar_w(input int addr_w, input int id_w);
        return addr_w + id_w + AR_ID_LSB;
    endfunction

    function automatic int r_w(input int data_w, input int id_w);
        return data_w + id_w + R_ID_LSB;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_e;

endpackage

// File: rtl/vexriscv_rr_arb2.sv
// Two-input round-robin grant unit; on a tie the source opposite the last grant wins.
// last_grant starts at 1 so source 0 wins the first tie after reset.
module vexriscv_rr_arb2 (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       upd_idx_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = (&req_i) ? ~last_grant_q : req_i[1];
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_i) begin
            last_grant_d = upd_idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/vexriscv_axi_rd_arbiter.sv
// Merges the VexRiscv ibus (source 0) and dbus (source 1) AXI4 read ports onto one master,
// one burst in flight, ARID tagged with the source index and R beats routed back by that tag.
module vexriscv_axi_rd_arbiter
    import vexriscv_axi_pkg::*;
#(
    parameter  int ID_WIDTH   = 1,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int AR_W       = ar_w(ADDR_WIDTH, ID_WIDTH),
    localparam int R_W        = r_w(DATA_WIDTH, ID_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s0_ar_valid,
    output logic            s0_ar_ready,
    input  logic [AR_W-1:0] s0_ar_payload,
    input  logic            s1_ar_valid,
    output logic            s1_ar_ready,
    input  logic [AR_W-1:0] s1_ar_payload,
    output logic            s0_r_valid,
    input  logic            s0_r_ready,
    output logic [R_W-1:0]  s0_r_payload,
    output logic            s1_r_valid,
    input  logic            s1_r_ready,
    output logic [R_W-1:0]  s1_r_payload,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AR_W:0]   m_ar_payload,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W:0]    m_r_payload,
    output logic            busy,
    output logic            err
);

    localparam int TAG_AR = AR_ID_LSB + ID_WIDTH;
    localparam int TAG_R  = R_ID_LSB + ID_WIDTH;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [AR_W-1:0]       pay_q, pay_d;
    logic [AR_LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;

    logic                  arb_valid, arb_idx, arb_update;
    logic                  r_last, r_tag;
    logic [R_W-1:0]        r_strip;

    vexriscv_rr_arb2 u_rr (
        .clk         (clk),
        .rst_ni      (reset),
        .req_i       ({s1_ar_valid, s0_ar_valid}),
        .update_i    (arb_update),
        .upd_idx_i   (grant_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // The source-index tag sits just above the source id in both the AR and R payloads.
    assign m_ar_payload = {pay_q[AR_W-1:TAG_AR], grant_q, pay_q[TAG_AR-1:0]};
    assign r_strip      = {m_r_payload[R_W:TAG_R+1], m_r_payload[TAG_R-1:0]};
    assign r_last       = m_r_payload[R_LAST_BIT];
    assign r_tag        = m_r_payload[TAG_R];
    assign s0_r_payload = r_strip;
    assign s1_r_payload = r_strip;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        pay_d       = pay_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        arb_update  = 1'b0;
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        m_ar_valid  = 1'b0;
        m_r_ready   = 1'b0;
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    s0_ar_ready = ~arb_idx;
                    s1_ar_ready = arb_idx;
                    grant_d     = arb_idx;
                    pay_d       = arb_idx ? s1_ar_payload : s0_ar_payload;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready) begin
                    beat_cnt_d = pay_q[AR_LEN_LSB +: AR_LEN_W];
                    state_d    = DATA;
                end
            end
            DATA: begin
                m_r_ready  = grant_q ? s1_r_ready : s0_r_ready;
                s0_r_valid = m_r_valid & ~grant_q;
                s1_r_valid = m_r_valid & grant_q;
                if (m_r_valid && m_r_ready) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    // Misrouted tag or last disagreeing with the programmed length is flagged but not acted on.
                    if ((r_tag != grant_q) || (r_last && (beat_cnt_q != '0)) ||
                        (!r_last && (beat_cnt_q == '0))) begin
                        err_d = 1'b1;
                    end
                    if (r_last) begin
                        arb_update = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            pay_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            pay_q      <= pay_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_vexriscv_axi_rd_arbiter.sv
// Directed bench for vexriscv_axi_rd_arbiter: stimulus pushes expected AR/R payloads into queues,
// a negedge monitor pops and compares on every handshake.
module tb_vexriscv_axi_rd_arbiter;

    localparam int ID_WIDTH   = 1;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int AR_W       = ADDR_WIDTH + ID_WIDTH + 25;
    localparam int R_W        = DATA_WIDTH + ID_WIDTH + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
    logic [AR_W-1:0] s0_ar_payload, s1_ar_payload;
    logic            s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
    logic [R_W-1:0]  s0_r_payload, s1_r_payload;
    logic            m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AR_W:0]   m_ar_payload;
    logic [R_W:0]    m_r_payload;
    logic            busy, err;

    always #5 clk = ~clk;

    vexriscv_axi_rd_arbiter #(
        .ID_WIDTH  (ID_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s0_ar_valid  (s0_ar_valid),
        .s0_ar_ready  (s0_ar_ready),
        .s0_ar_payload(s0_ar_payload),
        .s1_ar_valid  (s1_ar_valid),
        .s1_ar_ready  (s1_ar_ready),
        .s1_ar_payload(s1_ar_payload),
        .s0_r_valid   (s0_r_valid),
        .s0_r_ready   (s0_r_ready),
        .s0_r_payload (s0_r_payload),
        .s1_r_valid   (s1_r_valid),
        .s1_r_ready   (s1_r_ready),
        .s1_r_payload (s1_r_payload),
        .m_ar_valid   (m_ar_valid),
        .m_ar_ready   (m_ar_ready),
        .m_ar_payload (m_ar_payload),
        .m_r_valid    (m_r_valid),
        .m_r_ready    (m_r_ready),
        .m_r_payload  (m_r_payload),
        .busy         (busy),
        .err          (err)
    );

    logic [AR_W:0]  exp_ar[$];
    logic [R_W-1:0] exp_r0[$];
    logic [R_W-1:0] exp_r1[$];
    int             checks = 0;
    int             errors = 0;
    logic           exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] addr, input logic id, input logic [7:0] len);
        return {addr, id, len, 3'd2, 2'b01, 1'b0, 4'h3, 3'd0, 4'd0};
    endfunction

    function automatic logic [AR_W:0] mk_mar(input logic [31:0] addr, input logic src, input logic id,
                                             input logic [7:0] len);
        return {addr, src, id, len, 3'd2, 2'b01, 1'b0, 4'h3, 3'd0, 4'd0};
    endfunction

    function automatic logic [R_W:0] mk_mr(input logic [31:0] data, input logic src, input logic id,
                                           input logic [1:0] resp, input logic last);
        return {data, src, id, resp, last};
    endfunction

    function automatic logic [R_W-1:0] mk_sr(input logic [31:0] data, input logic id,
                                             input logic [1:0] resp, input logic last);
        return {data, id, resp, last};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (m_ar_valid && m_ar_ready) begin
                if (exp_ar.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ar_unexpected: actual 0x%0h required none", m_ar_payload);
                end else check("m_ar_payload", 64'(m_ar_payload), 64'(exp_ar.pop_front()));
            end
            if (s0_r_valid && s0_r_ready) begin
                if (exp_r0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r0_unexpected: actual 0x%0h required none", s0_r_payload);
                end else check("s0_r_payload", 64'(s0_r_payload), 64'(exp_r0.pop_front()));
            end
            if (s1_r_valid && s1_r_ready) begin
                if (exp_r1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r1_unexpected: actual 0x%0h required none", s1_r_payload);
                end else check("s1_r_payload", 64'(s1_r_payload), 64'(exp_r1.pop_front()));
            end
        end
    end

    task automatic req_wait(input logic src);
        int n = 0;
        #1;
        while (!(s0_ar_ready || s1_ar_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_src", 64'({s1_ar_ready, s0_ar_ready}), src ? 64'd2 : 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic serve(input logic src, input logic [AR_W:0] ar_exp, input logic id, input int n_beats,
                         input int last_idx, input int ar_delay, input bit toggle, input logic [31:0] base);
        logic rdy;
        logic lst;
        bit   acc;
        int   n;
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk);
            check("ar_valid_hold", 64'(m_ar_valid), 64'd1);
            check("ar_payload_hold", 64'(m_ar_payload), 64'(ar_exp));
            check("ar_ready_in_issue", 64'({s1_ar_ready, s0_ar_ready}), 64'd0);
            @(posedge clk); #1;
        end
        // R beat offered in the same cycle as m_ar_ready must not be taken.
        s0_r_ready  = 1'b1;
        s1_r_ready  = 1'b1;
        m_r_payload = mk_mr(base, src, id, 2'd0, last_idx == 0);
        m_r_valid   = 1'b1;
        m_ar_ready  = 1'b1;
        @(negedge clk);
        check("ar_valid", 64'(m_ar_valid), 64'd1);
        check("r_ready_in_issue", 64'(m_r_ready), 64'd0);
        check("r_valid_in_issue", 64'({s1_r_valid, s0_r_valid}), 64'd0);
        @(posedge clk); #1;
        m_ar_ready = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < n_beats; i++) begin
            lst = (i == last_idx);
            if (src) exp_r1.push_back(mk_sr(base + i, id, 2'(i), lst));
            else     exp_r0.push_back(mk_sr(base + i, id, 2'(i), lst));
            m_r_payload = mk_mr(base + i, src, id, 2'(i), lst);
            m_r_valid   = 1'b1;
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 40) begin
                if (src) begin s1_r_ready = rdy; s0_r_ready = 1'b1; end
                else     begin s0_r_ready = rdy; s1_r_ready = 1'b1; end
                @(negedge clk);
                check("m_r_ready_mirror", 64'(m_r_ready), 64'(rdy));
                check("other_r_valid", src ? 64'(s0_r_valid) : 64'(s1_r_valid), 64'd0);
                @(posedge clk); #1;
                n++;
                acc = rdy;
                if (toggle) rdy = ~rdy;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL beat_timeout: actual beat %0d not accepted required accepted", i);
            end
        end
        m_r_valid  = 1'b0;
        s0_r_ready = 1'b0;
        s1_r_ready = 1'b0;
        if (last_idx >= 0) begin
            @(negedge clk);
            check("busy_after_last", 64'(busy), 64'd0);
            check("err_after_burst", 64'(err), 64'(exp_err));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_ar_valid"}, 64'(m_ar_valid), 64'd0);
        check({tag, "_m_r_ready"}, 64'(m_r_ready), 64'd0);
        check({tag, "_s_ar_ready"}, 64'({s1_ar_ready, s0_ar_ready}), 64'd0);
        check({tag, "_s_r_valid"}, 64'({s1_r_valid, s0_r_valid}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_m_ar_payload"}, 64'(m_ar_payload), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        s0_ar_payload = '0; s1_ar_payload = '0;
        s0_r_ready = 1'b0; s1_r_ready = 1'b0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_payload = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        @(posedge clk); #1;

        // Single s0 burst, len=3, immediate m_ar_ready
        s0_ar_payload = mk_ar(32'h1000, 1'b0, 8'd3);
        exp_ar.push_back(mk_mar(32'h1000, 1'b0, 1'b0, 8'd3));
        s0_ar_valid = 1'b1;
        req_wait(1'b0);
        s0_ar_valid = 1'b0;
        check("busy_in_issue", 64'(busy), 64'd1);
        serve(1'b0, mk_mar(32'h1000, 1'b0, 1'b0, 8'd3), 1'b0, 4, 3, 0, 1'b0, 32'hA000_0000);

        // Tie straight after reset, then continuous requests alternate 0,1,0,1
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        s0_ar_payload = mk_ar(32'h2000, 1'b1, 8'd0);
        s1_ar_payload = mk_ar(32'h3000, 1'b0, 8'd0);
        s0_ar_valid = 1'b1;
        s1_ar_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k[0]) begin
                exp_ar.push_back(mk_mar(32'h3000, 1'b1, 1'b0, 8'd0));
                req_wait(1'b1);
                serve(1'b1, mk_mar(32'h3000, 1'b1, 1'b0, 8'd0), 1'b0, 1, 0, 0, 1'b0, 32'hB000_0000 + k);
            end else begin
                exp_ar.push_back(mk_mar(32'h2000, 1'b0, 1'b1, 8'd0));
                req_wait(1'b0);
                serve(1'b0, mk_mar(32'h2000, 1'b0, 1'b1, 8'd0), 1'b1, 1, 0, 0, 1'b0, 32'hC000_0000 + k);
            end
        end
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;

        // m_ar_ready held low for 5 cycles
        s0_ar_payload = mk_ar(32'h4000, 1'b1, 8'd1);
        exp_ar.push_back(mk_mar(32'h4000, 1'b0, 1'b1, 8'd1));
        s0_ar_valid = 1'b1;
        req_wait(1'b0);
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b1;
        s1_ar_payload = mk_ar(32'h4400, 1'b1, 8'd0);
        serve(1'b0, mk_mar(32'h4000, 1'b0, 1'b1, 8'd1), 1'b1, 2, 1, 5, 1'b0, 32'hD000_0000);
        s1_ar_valid = 1'b0;
        #1;

        // s1 len=7 with r_ready toggling
        s1_ar_payload = mk_ar(32'h5000, 1'b1, 8'd7);
        exp_ar.push_back(mk_mar(32'h5000, 1'b1, 1'b1, 8'd7));
        s1_ar_valid = 1'b1;
        req_wait(1'b1);
        s1_ar_valid = 1'b0;
        serve(1'b1, mk_mar(32'h5000, 1'b1, 1'b1, 8'd7), 1'b1, 8, 7, 0, 1'b1, 32'hE000_0000);

        // Early last on beat 2 of len=3: sticky err
        s0_ar_payload = mk_ar(32'h6000, 1'b0, 8'd3);
        exp_ar.push_back(mk_mar(32'h6000, 1'b0, 1'b0, 8'd3));
        s0_ar_valid = 1'b1;
        req_wait(1'b0);
        s0_ar_valid = 1'b0;
        exp_err = 1'b1;
        serve(1'b0, mk_mar(32'h6000, 1'b0, 1'b0, 8'd3), 1'b0, 3, 2, 0, 1'b0, 32'h1111_0000);
        s1_ar_payload = mk_ar(32'h6100, 1'b0, 8'd1);
        exp_ar.push_back(mk_mar(32'h6100, 1'b1, 1'b0, 8'd1));
        s1_ar_valid = 1'b1;
        req_wait(1'b1);
        s1_ar_valid = 1'b0;
        serve(1'b1, mk_mar(32'h6100, 1'b1, 1'b0, 8'd1), 1'b0, 2, 1, 0, 1'b0, 32'h2222_0000);

        // Asynchronous reset during beat 2 of a len=3 burst
        s0_ar_payload = mk_ar(32'h7000, 1'b0, 8'd3);
        exp_ar.push_back(mk_mar(32'h7000, 1'b0, 1'b0, 8'd3));
        s0_ar_valid = 1'b1;
        req_wait(1'b0);
        s0_ar_valid = 1'b0;
        serve(1'b0, mk_mar(32'h7000, 1'b0, 1'b0, 8'd3), 1'b0, 2, -1, 0, 1'b0, 32'h3333_0000);
        m_r_payload = mk_mr(32'h3333_0002, 1'b0, 1'b0, 2'd2, 1'b0);
        m_r_valid   = 1'b1;
        s0_r_ready  = 1'b1;
        #1;
        check("s0_r_valid_mid_burst", 64'(s0_r_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_r_valid  = 1'b0;
        s0_r_ready = 1'b0;
        exp_err    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        s1_ar_payload = mk_ar(32'h8000, 1'b1, 8'd0);
        exp_ar.push_back(mk_mar(32'h8000, 1'b1, 1'b1, 8'd0));
        s1_ar_valid = 1'b1;
        req_wait(1'b1);
        s1_ar_valid = 1'b0;
        serve(1'b1, mk_mar(32'h8000, 1'b1, 1'b1, 8'd0), 1'b1, 1, 0, 0, 1'b0, 32'h4444_0000);

        @(negedge clk);
        check("exp_ar_drained", 64'(exp_ar.size()), 64'd0);
        check("exp_r0_drained", 64'(exp_r0.size()), 64'd0);
        check("exp_r1_drained", 64'(exp_r1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
